fft_frame_sequencer: RTL and testbench

Frame controller for the 8-point FFT datapath (three cascaded butterfly stages). It accepts complex samples one per handshake, places them in bit-reversed order on the datapath's parallel input bus, and holds that bus stable for the datapath's pipeline latency. It then captures the eight parallel results and streams them out in natural order with a valid/ready handshake. Frames are processed one at a time and never overlap.

---
 rtl/fft_frame_sequencer.sv | 124 ++++++++++++
 tb/tb_fft_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for an 8-point FFT datapath: loads samples in bit-reversed slot order,
// holds the datapath input for LAT+1 cycles, then drains captured results in natural order.
module fft_frame_sequencer #(
  parameter int N   = 3,
  parameter int LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2**N-1:0]   in_r_i,
  input  logic [2**N-1:0]   in_i_i,
  output logic [8*2**N-1:0] dp_in_r_o,
  output logic [8*2**N-1:0] dp_in_i_o,
  input  logic [8*2**N-1:0] dp_out_r_i,
  input  logic [8*2**N-1:0] dp_out_i_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2**N-1:0]   out_r_o,
  output logic [2**N-1:0]   out_i_o,
  output logic              out_last_o,
  output logic              busy_o
);
  localparam int         W     = 2**N;
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [2:0]     ld_cnt_q, ld_cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [3:0]     run_cnt_q, run_cnt_d;
  logic [8*W-1:0] dp_r_q, dp_r_d, dp_i_q, dp_i_d;
  logic [8*W-1:0] buf_r_q, buf_r_d, buf_i_q, buf_i_d;
  logic           in_hs, out_hs, capture;
  logic [2:0]     slot;

  // abort wins over any handshake in the same cycle
  assign in_hs   = in_valid_i && in_ready_o && !abort_i;
  assign out_hs  = out_valid_o && out_ready_i && !abort_i;
  assign capture = (state_q == S_RUN) && (run_cnt_q == LAT_C) && !abort_i;
  assign slot    = {ld_cnt_q[0], ld_cnt_q[1], ld_cnt_q[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (in_hs && ld_cnt_q == 3'd7) state_d = S_RUN;
      S_RUN:   if (capture) state_d = S_DRAIN;
      S_DRAIN: if (out_hs && idx_q == 3'd7) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
    if (abort_i) state_d = S_LOAD;
  end

  always_comb begin
    in_ready_o  = (state_q == S_LOAD) && !rst;
    out_valid_o = (state_q == S_DRAIN);
    out_last_o  = (state_q == S_DRAIN) && (idx_q == 3'd7);
    busy_o      = (state_q != S_LOAD) || (ld_cnt_q != 3'd0);
    out_r_o     = '0;
    out_i_o     = '0;
    if (state_q == S_DRAIN) begin
      out_r_o = buf_r_q[int'(idx_q)*W +: W];
      out_i_o = buf_i_q[int'(idx_q)*W +: W];
    end
  end

  // counters and data storage; dp_in survives an abort and is simply overwritten later
  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    idx_d     = idx_q;
    run_cnt_d = '0;
    dp_r_d    = dp_r_q;
    dp_i_d    = dp_i_q;
    buf_r_d   = buf_r_q;
    buf_i_d   = buf_i_q;
    if (in_hs) begin
      ld_cnt_d = ld_cnt_q + 3'd1;
      dp_r_d[int'(slot)*W +: W] = in_r_i;
      dp_i_d[int'(slot)*W +: W] = in_i_i;
    end
    if (state_q == S_RUN && !capture) run_cnt_d = run_cnt_q + 4'd1;
    if (capture) begin
      buf_r_d = dp_out_r_i;
      buf_i_d = dp_out_i_i;
    end
    if (out_hs) idx_d = idx_q + 3'd1;
    if (abort_i) begin
      ld_cnt_d  = '0;
      run_cnt_d = '0;
      idx_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt_q  <= '0;
      idx_q     <= '0;
      run_cnt_q <= '0;
      dp_r_q    <= '0;
      dp_i_q    <= '0;
      buf_r_q   <= '0;
      buf_i_q   <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      idx_q     <= idx_d;
      run_cnt_q <= run_cnt_d;
      dp_r_q    <= dp_r_d;
      dp_i_q    <= dp_i_d;
      buf_r_q   <= buf_r_d;
      buf_i_q   <= buf_i_d;
    end
  end

  assign dp_in_r_o = dp_r_q;
  assign dp_in_i_o = dp_i_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: two instances (LAT=3 and LAT=5) behind identity delay-line
// datapaths, checked against a slot-placement model of the frame.
module tb_fft_frame_sequencer;
  localparam int W  = 8;
  localparam int LA = 3;
  localparam int LB = 5;

  logic clk = 1'b0, rst = 1'b1, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0, use_b = 1'b0;
  logic [W-1:0] in_r = '0, in_i = '0;

  logic a_in_ready, a_out_valid, a_out_last, a_busy;
  logic b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [W-1:0] a_out_r, a_out_i, b_out_r, b_out_i;
  logic [8*W-1:0] a_dpi_r, a_dpi_i, a_dpo_r, a_dpo_i;
  logic [8*W-1:0] b_dpi_r, b_dpi_i, b_dpo_r, b_dpo_i;
  logic [8*W-1:0] a_pr [LA], a_pi [LA], b_pr [LB], b_pi [LB];

  logic           in_rdy, out_vld, o_last, busy;
  logic [W-1:0]   o_r, o_i;
  logic [8*W-1:0] dp_r, dp_i;

  logic [7:0] frame_r [8], frame_i [8], mdl_r [8], mdl_i [8];
  int lat;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // identity datapaths: dp_out is dp_in delayed by LAT registers
  always @(posedge clk) begin
    a_pr[0] <= a_dpi_r; a_pi[0] <= a_dpi_i;
    for (int s = 1; s < LA; s++) begin a_pr[s] <= a_pr[s-1]; a_pi[s] <= a_pi[s-1]; end
    b_pr[0] <= b_dpi_r; b_pi[0] <= b_dpi_i;
    for (int s = 1; s < LB; s++) begin b_pr[s] <= b_pr[s-1]; b_pi[s] <= b_pi[s-1]; end
  end
  assign a_dpo_r = a_pr[LA-1];
  assign a_dpo_i = a_pi[LA-1];
  assign b_dpo_r = b_pr[LB-1];
  assign b_dpo_i = b_pi[LB-1];

  fft_frame_sequencer #(.N(3), .LAT(LA)) u_dut_a (
    .clk(clk), .rst(rst), .abort_i(abort & ~use_b), .in_valid_i(in_valid & ~use_b),
    .in_ready_o(a_in_ready), .in_r_i(in_r), .in_i_i(in_i),
    .dp_in_r_o(a_dpi_r), .dp_in_i_o(a_dpi_i), .dp_out_r_i(a_dpo_r), .dp_out_i_i(a_dpo_i),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready & ~use_b), .out_r_o(a_out_r),
    .out_i_o(a_out_i), .out_last_o(a_out_last), .busy_o(a_busy));

  fft_frame_sequencer #(.N(3), .LAT(LB)) u_dut_b (
    .clk(clk), .rst(rst), .abort_i(abort & use_b), .in_valid_i(in_valid & use_b),
    .in_ready_o(b_in_ready), .in_r_i(in_r), .in_i_i(in_i),
    .dp_in_r_o(b_dpi_r), .dp_in_i_o(b_dpi_i), .dp_out_r_i(b_dpo_r), .dp_out_i_i(b_dpo_i),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready & use_b), .out_r_o(b_out_r),
    .out_i_o(b_out_i), .out_last_o(b_out_last), .busy_o(b_busy));

  assign in_rdy  = use_b ? b_in_ready  : a_in_ready;
  assign out_vld = use_b ? b_out_valid : a_out_valid;
  assign o_last  = use_b ? b_out_last  : a_out_last;
  assign busy    = use_b ? b_busy      : a_busy;
  assign o_r     = use_b ? b_out_r     : a_out_r;
  assign o_i     = use_b ? b_out_i     : a_out_i;
  assign dp_r    = use_b ? b_dpi_r     : a_dpi_r;
  assign dp_i    = use_b ? b_dpi_i     : a_dpi_i;

  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mdl();
    for (int s = 0; s < 8; s++) begin mdl_r[s] = '0; mdl_i[s] = '0; end
  endtask

  task automatic new_frame();
    for (int k = 0; k < 8; k++) begin frame_r[k] = 8'($urandom); frame_i[k] = 8'($urandom); end
  endtask

  // vmode: 0 continuous, 1 toggling, 2 random in_valid
  task automatic send(input int n, input int vmode);
    int k = 0;
    int guard = 0;
    bit tog = 1'b1;
    logic v;
    while (k < n && guard < 300) begin
      @(negedge clk); guard++;
      chk("load_in_ready", in_rdy, 1);
      chk("load_busy", busy, (k != 0));
      case (vmode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v; in_r = frame_r[k]; in_i = frame_i[k];
      if (v) begin
        mdl_r[rev3(k)] = frame_r[k];
        mdl_i[rev3(k)] = frame_i[k];
        k++;
      end
    end
    if (k != n) chk("send_timeout", k, n);
  endtask

  task automatic run_wait();
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk); in_valid = 1'b0;
      chk("run_in_ready", in_rdy, 0);
      chk("run_out_valid", out_vld, 0);
      chk("run_busy", busy, 1);
      if (c == 0)
        for (int s = 0; s < 8; s++) begin
          chk("dp_slot_r", dp_r[s*8 +: 8], mdl_r[s]);
          chk("dp_slot_i", dp_i[s*8 +: 8], mdl_i[s]);
        end
    end
  endtask

  // rmode: 0 always ready, 1 five-cycle stall at bin 3, 2 random; abort_at < 0 means no abort
  task automatic recv(input int rmode, input int abort_at);
    int j = 0;
    int guard = 0;
    int hold = 0;
    bit ab = 1'b0;
    logic r;
    while (j < 8 && !ab && guard < 300) begin
      @(negedge clk); guard++;
      chk("drain_out_valid", out_vld, 1);
      chk("drain_in_ready", in_rdy, 0);
      chk("out_r", o_r, mdl_r[j]);
      chk("out_i", o_i, mdl_i[j]);
      chk("out_last", o_last, (j == 7));
      case (rmode)
        0:       r = 1'b1;
        1:       if (j == 3 && hold < 5) begin r = 1'b0; hold++; end else r = 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (j == abort_at) begin abort = 1'b1; out_ready = 1'b1; ab = 1'b1; end
      else if (r) j++;
    end
    if (j != 8 && !ab) chk("recv_timeout", j, 8);
    @(negedge clk); abort = 1'b0; out_ready = 1'b0;
    chk("post_out_valid", out_vld, 0);
    chk("post_in_ready", in_rdy, 1);
    chk("post_busy", busy, 0);
    chk("post_out_last", o_last, 0);
  endtask

  task automatic run_full(input int vmode, input int rmode);
    new_frame();
    send(8, vmode);
    run_wait();
    recv(rmode, -1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_rdy, 0);
    chk({tag, "_out_valid"}, out_vld, 0);
    chk({tag, "_out_last"}, o_last, 0);
    chk({tag, "_out_r"}, o_r, 0);
    chk({tag, "_out_i"}, o_i, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dp_r"}, dp_r, 0);
    chk({tag, "_dp_i"}, dp_i, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    lat = LA;
    clear_mdl();
    #2;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_in_ready", in_rdy, 1);

    // basic frame: in_r = k+1, in_i = -(k+1)
    for (int k = 0; k < 8; k++) begin frame_r[k] = 8'(k + 1); frame_i[k] = 8'(-(k + 1)); end
    send(8, 0);
    run_wait();
    recv(0, -1);
    chk("basic_dp_r", dp_r, 64'h0804060207030501);
    chk("basic_dp_i", dp_i, 64'hF8FCFAFEF9FDFBFF);

    // backpressure at bin 3, then in_valid stalls
    new_frame(); send(8, 0); run_wait(); recv(1, -1);
    run_full(1, 0);

    // abort after five samples, fresh frame afterwards
    new_frame();
    send(5, 0);
    @(negedge clk); in_valid = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_load_in_ready", in_rdy, 1);
    chk("abort_load_busy", busy, 0);
    chk("abort_load_out_valid", out_vld, 0);
    run_full(0, 0);

    // abort during drain at bin 2
    new_frame(); send(8, 0); run_wait(); recv(0, 2);
    run_full(0, 0);

    // abort coincident with sample 7
    new_frame();
    frame_r[7] = ~mdl_r[7];
    frame_i[7] = ~mdl_i[7];
    send(7, 0);
    @(negedge clk); in_valid = 1'b1; in_r = frame_r[7]; in_i = frame_i[7]; abort = 1'b1;
    @(negedge clk); abort = 1'b0; in_valid = 1'b0;
    chk("abort7_in_ready", in_rdy, 1);
    chk("abort7_busy", busy, 0);
    chk("abort7_slot7_r", dp_r[56 +: 8], mdl_r[7]);
    chk("abort7_slot7_i", dp_i[56 +: 8], mdl_i[7]);
    repeat (lat + 3) begin
      @(negedge clk);
      chk("abort7_no_run_valid", out_vld, 0);
      chk("abort7_no_run_ready", in_rdy, 1);
    end
    run_full(0, 0);

    // random handshakes on both sides
    repeat (4) run_full(2, 2);

    // LAT = 5 instance: clean frame, then asynchronous reset mid-RUN
    @(negedge clk); use_b = 1'b1; lat = LB;
    clear_mdl();
    run_full(0, 0);
    new_frame();
    send(8, 0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    clear_mdl();
    @(negedge clk); rst = 1'b0;
    #1 chk("async_rst_release_ready", in_rdy, 1);
    run_full(0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
